// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_hs
// Purpose  : Byte-addressable RV32I data memory behind a valid/ready
//            request/response handshake. Configurable read latency,
//            misaligned/illegal-funct3 detection, and a registered response
//            that holds under back-pressure. One request outstanding at most.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_hs #(
  parameter int ADDR_W        = 9,
  parameter int READ_LAT      = 1,
  parameter int TRAP_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              busy
);

  localparam logic [2:0] C_LAT_M1 = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic [31:0]       r_rdata;
  logic              r_fault;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  logic              w_accept;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_ba [4];
  logic [7:0]        w_b  [4];
  logic [31:0]       w_load;

  // Acceptance is gated by rst_n so nothing is committed while reset is held.
  assign w_accept   = rst_n && req_valid && (r_state == S_IDLE);

  assign w_is_half  = (req_funct3[1:0] == 2'b01);
  assign w_is_word  = (req_funct3[1:0] == 2'b10);
  // Loads: 011/110/111 illegal. Stores: only SB/SH/SW (000..010) legal.
  assign w_illegal  = req_write ? (req_funct3 > 3'd2)
                                : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_misalign = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
  assign w_fault    = w_illegal || ((TRAP_MISALIGN != 0) && w_misalign);

  // Effective address: with trapping disabled, force natural alignment.
  always_comb begin
    w_addr = req_addr;
    if (TRAP_MISALIGN == 0) begin
      if (w_is_half) w_addr[0]   = 1'b0;
      if (w_is_word) w_addr[1:0] = 2'b00;
    end
  end

  // Byte lanes wrap modulo 4 inside the aligned word, so the top word stays in range.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_ba[i] = {w_addr[ADDR_W-1:2], 2'(w_addr[1:0] + 2'(i))};
    assign w_b[i]  = r_mem[w_ba[i]];
  end

  // Load data extension by funct3.
  always_comb begin
    w_load = 32'd0;
    case (req_funct3)
      3'b000:  w_load = {{24{w_b[0][7]}}, w_b[0]};
      3'b001:  w_load = {{16{w_b[1][7]}}, w_b[1], w_b[0]};
      3'b010:  w_load = {w_b[3], w_b[2], w_b[1], w_b[0]};
      3'b100:  w_load = {24'd0, w_b[0]};
      3'b101:  w_load = {16'd0, w_b[1], w_b[0]};
      default: w_load = 32'd0;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (READ_LAT == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, counter and response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= (req_write || w_fault) ? 32'd0 : w_load;
        r_fault <= w_fault;
      end
    end
  end

  // Array write at acceptance; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_fault) begin
      r_mem[w_ba[0]] <= req_wdata[7:0];
      if (w_is_half || w_is_word) r_mem[w_ba[1]] <= req_wdata[15:8];
      if (w_is_word) begin
        r_mem[w_ba[2]] <= req_wdata[23:16];
        r_mem[w_ba[3]] <= req_wdata[31:24];
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_hs
// Purpose  : Directed self-checking bench for data_mem_hs. Two instances:
//            u0 (READ_LAT=1, TRAP_MISALIGN=1) and u1 (READ_LAT=3,
//            TRAP_MISALIGN=0); sel routes requests and observation.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rr0, rv0, fl0, bz0, rr1, rv1, fl1, bz1;
  logic [31:0] rd0, rd1;
  logic        vin0, vin1;

  int total = 0;
  int bad   = 0;

  assign vin0 = req_valid && !sel;
  assign vin1 = req_valid &&  sel;

  wire        m_ready = sel ? rr1 : rr0;
  wire        m_valid = sel ? rv1 : rv0;
  wire        m_fault = sel ? fl1 : fl0;
  wire        m_busy  = sel ? bz1 : bz0;
  wire [31:0] m_rdata = sel ? rd1 : rd0;

  always #5 clk = ~clk;

  data_mem_hs #(.ADDR_W(9), .READ_LAT(1), .TRAP_MISALIGN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vin0), .req_ready(rr0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_fault(fl0), .busy(bz0)
  );

  data_mem_hs #(.ADDR_W(9), .READ_LAT(3), .TRAP_MISALIGN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vin1), .req_ready(rr1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_fault(fl1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  32'(m_ready), 32'd1);
    chk({tag, ".resp_valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".resp_rdata"}, m_rdata,      32'd0);
    chk({tag, ".resp_fault"}, 32'(m_fault), 32'd0);
    chk({tag, ".busy"},       32'(m_busy),  32'd0);
  endtask

  // Issue one request with resp_ready high; check latency, data, fault, return to idle.
  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [8:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_f, input int lat);
    int n;
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    chk({tag, ".req_ready"}, 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!m_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".rdata"},   m_rdata, exp_rd);
    chk({tag, ".fault"},   32'(m_fault), 32'(exp_f));
    @(posedge clk);
    #1;
    chk({tag, ".idle"}, {30'd0, m_valid, m_ready}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 9'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst1");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Instance 0: READ_LAT=1, TRAP_MISALIGN=1 ----
    txn("sw010",   1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0, 1);
    txn("lw010",   0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1);
    txn("sw020",   1, 3'b010, 9'h020, 32'h0,        32'h0,        0, 1);
    txn("sb021",   1, 3'b000, 9'h021, 32'h00000080, 32'h0,        0, 1);
    txn("lb021",   0, 3'b000, 9'h021, 32'h0,        32'hFFFFFF80, 0, 1);
    txn("lbu021",  0, 3'b100, 9'h021, 32'h0,        32'h00000080, 0, 1);
    txn("lh020",   0, 3'b001, 9'h020, 32'h0,        32'hFFFF8000, 0, 1);
    txn("lhu010",  0, 3'b101, 9'h010, 32'h0,        32'h0000BEEF, 0, 1);
    txn("lh012",   0, 3'b001, 9'h012, 32'h0,        32'hFFFFDEAD, 0, 1);
    txn("lw013m",  0, 3'b010, 9'h013, 32'h0,        32'h0,        1, 1);
    txn("sh011m",  1, 3'b001, 9'h011, 32'h0000AAAA, 32'h0,        1, 1);
    txn("lw010b",  0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1);
    txn("ld111",   0, 3'b111, 9'h010, 32'h0,        32'h0,        1, 1);
    txn("st011",   1, 3'b011, 9'h010, 32'h11111111, 32'h0,        1, 1);
    txn("lw010c",  0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 1);

    // ---- Instance 1: READ_LAT=3, TRAP_MISALIGN=0 ----
    sel = 1'b1;
    txn("u1sw010", 1, 3'b010, 9'h010, 32'hCAFEF00D, 32'h0,        0, 3);
    txn("u1lw013", 0, 3'b010, 9'h013, 32'h0,        32'hCAFEF00D, 0, 3);
    txn("u1sh011", 1, 3'b001, 9'h011, 32'h00001234, 32'h0,        0, 3);
    txn("u1lw010", 0, 3'b010, 9'h010, 32'h0,        32'hCAFE1234, 0, 3);
    txn("u1ld110", 0, 3'b110, 9'h010, 32'h0,        32'h0,        1, 3);

    // Back-pressure: resp_ready low for 5 cycles after resp_valid rises.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 9'h010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 1;
    while (!m_valid && n < 10) begin
      chk("bp.ready_wait", 32'(m_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp.latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_rdata", m_rdata, 32'hCAFE1234);
      chk("bp.hold_valid", 32'(m_valid), 32'd1);
      chk("bp.hold_ready", 32'(m_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    chk("bp.pre_hs_ready", 32'(m_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bp.post_valid", 32'(m_valid), 32'd0);
    chk("bp.post_ready", 32'(m_ready), 32'd1);

    // Reset pulse during WAIT after a store to the top word.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 9'h1FC;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rw.busy", 32'(m_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rw");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rw.no_valid", 32'(m_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    txn("u1lw1fc", 0, 3'b010, 9'h1FC, 32'h0, 32'h12345678, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
